// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: default word width, counter sizing and FSM encoding.
package spi_pkg;

    localparam int unsigned DATA_W = 16;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DATA_W);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall pulses taken from the
// last stage against one extra registered copy.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins on the system clock, receives one MSB-first
// word per chip-select frame and shifts a transmit word back out at the same time.
module spi_slave #(
    parameter int unsigned  DATA_W      = spi_pkg::DATA_W,
    parameter int unsigned  SYNC_STAGES = 2,
    localparam int unsigned CW          = spi_pkg::cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_l,
    input  logic              spi_clk,
    input  logic              spi_data,
    output logic              master_data,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [CW-1:0]     counter
);

    import spi_pkg::*;

    localparam logic [CW-1:0] FULL = CW'(DATA_W);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic data_level, data_rise_unused, data_fall_unused;

    // Chip select presets high so reset release never looks like a select edge.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .din   (spi_cs_l),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (spi_clk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .din   (spi_data),
        .level (data_level),
        .rise  (data_rise_unused),
        .fall  (data_fall_unused)
    );

    state_e            state_q, state_d;
    logic [CW-1:0]     counter_q, counter_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              md_q, md_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    // A frame may only start once chip select has been seen high after the synchronizers
    // have flushed; a frame already running at reset release is thereby ignored.
    logic [SYNC_STAGES:0] warm_q;
    logic                 armed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            warm_q  <= {warm_q[SYNC_STAGES-1:0], 1'b1};
            armed_q <= armed_q | (warm_q[SYNC_STAGES] & cs_level);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            md_q        <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            md_q        <= md_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        md_d        = md_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                md_d = 1'b0;
                if (cs_fall && armed_q) begin
                    tx_shift_d = tx_data;
                    md_d       = tx_data[DATA_W-1];
                    counter_d  = '0;
                    state_d    = StShift;
                end
            end

            StShift: begin
                if (counter_q == FULL) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    md_d       = 1'b0;
                    // A select release landing on the completion cycle must not strand DONE.
                    if (cs_rise) begin
                        counter_d = '0;
                        state_d   = StIdle;
                    end else begin
                        state_d = StDone;
                    end
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    md_d        = 1'b0;
                    counter_d   = '0;
                    state_d     = StIdle;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], data_level};
                        counter_d  = counter_q + CW'(1);
                    end
                    if (sclk_fall) begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        md_d       = tx_shift_q[DATA_W-2];
                    end
                end
            end

            StDone: begin
                md_d = 1'b0;
                if (cs_rise) begin
                    counter_d = '0;
                    state_d   = StIdle;
                end
            end

            default: begin
                md_d      = 1'b0;
                counter_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    assign master_data = md_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != StIdle);
    assign counter     = counter_q;

endmodule
